// File: rtl/fifo_buffer_memory_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
package fifo_buffer_memory_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 8;

    // Per-cycle operation, encoded as {write_accepted, read_accepted}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_buffer_memory_if.sv
// Producer/consumer bus of the FIFO; master drives requests, slave is the FIFO.
interface fifo_buffer_memory_if
    import fifo_buffer_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  enable;
    logic                  write;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;

    modport master (
        output enable, write, data_in, read,
        input  data_out, empty, full
    );

    modport slave (
        input  enable, write, data_in, read,
        output data_out, empty, full
    );
endinterface

// File: rtl/fifo_buffer_memory.sv
// Single-clock FIFO with registered read data and a global enable that freezes all state.
module fifo_buffer_memory
    import fifo_buffer_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    fifo_buffer_memory_if.slave   bus
);

    localparam int unsigned ADDR_WIDTH = addr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  empty;
    logic                  full;
    logic                  do_read;
    logic                  do_write;
    fifo_op_e              op;

    assign empty = (count == '0);
    assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));

    // A write into a full FIFO is allowed only when a read frees a slot on the same edge
    assign do_read  = bus.enable && bus.read && !empty;
    assign do_write = bus.enable && bus.write && (!full || do_read);
    assign op       = fifo_op_e'({do_write, do_read});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            data_q <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_read) begin
                data_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case (op)
                OP_WRITE: count <= count + (ADDR_WIDTH+1)'(1);
                OP_READ:  count <= count - (ADDR_WIDTH+1)'(1);
                default:  count <= count;
            endcase
        end
    end

    // Storage is deliberately not cleared by reset
    always_ff @(posedge clock) begin
        if (do_write && !reset) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    assign bus.data_out = data_q;
    assign bus.empty    = empty;
    assign bus.full     = full;

endmodule

// File: tb/tb_fifo_buffer_memory.sv
// Directed and randomized checks of fifo_buffer_memory against a queue-based reference.
module tb_fifo_buffer_memory;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fifo_buffer_memory_if #(.DATA_WIDTH(DW)) bus ();

    fifo_buffer_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout = '0;
    logic          saw_nine = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, bus.data_out, exp_dout);
        check({tag, ".empty"}, DW'(bus.empty), DW'(model_q.size() == 0));
        check({tag, ".full"},  DW'(bus.full),  DW'(model_q.size() == DEPTH));
    endtask

    // Drive one cycle from a negedge, evaluate the FIFO rules on the pre-edge contents, check, return at negedge
    task automatic step(input string tag, input logic en, input logic wr,
                        input logic rd, input logic [DW-1:0] din);
        logic rd_ok;
        logic wr_ok;
        bus.enable  = en;
        bus.write   = wr;
        bus.read    = rd;
        bus.data_in = din;
        @(posedge clock);
        #1;
        rd_ok = en && rd && (model_q.size() > 0);
        wr_ok = en && wr && ((model_q.size() < DEPTH) || rd_ok);
        if (rd_ok) exp_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(din);
        check_all(tag);
        @(negedge clock);
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.data_in = '0;

        // Reset state
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b0;
        @(negedge clock);

        // 1) underflow right after reset
        step("underflow", 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("underflow.dout_zero", bus.data_out, 32'h0);

        // 2) fill with 0..7
        for (int i = 0; i < 8; i++) begin
            step("fill", 1'b1, 1'b1, 1'b0, DW'(i));
            if (i == 0) check("fill.empty_falls", DW'(bus.empty), 32'h0);
        end
        check("fill.full_after_8", DW'(bus.full), 32'h1);

        // 3) read 10 cycles: 0..7 then hold 7
        for (int i = 0; i < 10; i++) begin
            step("drain", 1'b1, 1'b0, 1'b1, '0);
            check("drain.value", bus.data_out, (i < 8) ? DW'(i) : 32'h7);
            if (i == 0) check("drain.full_falls", DW'(bus.full), 32'h0);
        end
        check("drain.empty_after_8", DW'(bus.empty), 32'h1);

        // 4) overflow is ignored
        for (int i = 0; i < 8; i++) step("ovf_fill", 1'b1, 1'b1, 1'b0, 32'h100 + DW'(i));
        step("ovf_write9", 1'b1, 1'b1, 1'b0, 32'h9);
        for (int i = 0; i < 8; i++) begin
            step("ovf_drain", 1'b1, 1'b0, 1'b1, '0);
            check("ovf_drain.value", bus.data_out, 32'h100 + DW'(i));
            if (bus.data_out == 32'h9) saw_nine = 1'b1;
        end
        check("ovf.never_nine", DW'(saw_nine), 32'h0);

        // Simultaneous read+write while empty: write only
        step("rw_empty", 1'b1, 1'b1, 1'b1, 32'h55);
        check("rw_empty.not_empty", DW'(bus.empty), 32'h0);
        step("rw_empty_read", 1'b1, 1'b0, 1'b1, '0);
        check("rw_empty.value", bus.data_out, 32'h55);

        // Simultaneous read+write while full: both happen, full stays
        for (int i = 0; i < 8; i++) step("rw_full_fill", 1'b1, 1'b1, 1'b0, $urandom);
        step("rw_full", 1'b1, 1'b1, 1'b1, 32'hABCD);
        check("rw_full.full_stays", DW'(bus.full), 32'h1);

        // 5) enable low freezes everything
        for (int i = 0; i < 3; i++) step("frozen", 1'b0, 1'b1, 1'b1, 32'hFFFF_0000);
        for (int i = 0; i < 8; i++) step("frozen_drain", 1'b1, 1'b0, 1'b1, '0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(9) != 0), $urandom_range(1) == 1,
                 $urandom_range(1) == 1, $urandom);
        end

        // 6) asynchronous reset mid-read
        for (int i = 0; i < 8; i++) step("pre_rst_drain", 1'b1, 1'b0, 1'b1, '0);
        step("pre_rst_w8", 1'b1, 1'b1, 1'b0, 32'h8);
        step("pre_rst_w9", 1'b1, 1'b1, 1'b0, 32'h9);
        bus.read  = 1'b1;
        bus.write = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_q.delete();
        exp_dout = '0;
        check("async_rst.data_out", bus.data_out, 32'h0);
        check("async_rst.empty", DW'(bus.empty), 32'h1);
        check("async_rst.full", DW'(bus.full), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all("post_rst");
        step("post_rst_wA", 1'b1, 1'b1, 1'b0, 32'hA);
        step("post_rst_rA", 1'b1, 1'b0, 1'b1, '0);
        check("post_rst.value", bus.data_out, 32'hA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
